// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller.
// Moore outputs registered from the next-state decode; beq PC write follows Zero.
module mc_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       rf_wr,
  output logic       reg_dst,
  output logic       wd_sel,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       ext_op,
  output logic       dm_wr,
  output logic [3:0] ALUop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXE_R   = 4'd6,
    S_ALU_WB  = 4'd7,
    S_EXE_I   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       rf_wr;
    logic       reg_dst;
    logic       wd_sel;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic       ext_op;
    logic       dm_wr;
    logic [3:0] alu;
  } ctl_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic [1:0] SB_B    = 2'd0;
  localparam logic [1:0] SB_FOUR = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_BOFS = 2'd3;

  state_t cur;
  state_t nxt;
  ctl_t   ctl_q;
  ctl_t   ctl_d;

  function automatic logic known_funct(input logic [5:0] f);
    return (f == F_ADDU) || (f == F_SUBU) || (f == F_AND) ||
           (f == F_OR) || (f == F_XOR);
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    logic [3:0] a;
    a = ALU_ADD;
    unique case (1'b1)
      (f == F_SUBU): a = ALU_SUB;
      (f == F_AND):  a = ALU_AND;
      (f == F_OR):   a = ALU_OR;
      (f == F_XOR):  a = ALU_XOR;
      default:       a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic state_t next_of(
    input state_t     s,
    input logic [5:0] o,
    input logic [5:0] f
  );
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH: n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (o == OP_LW) || (o == OP_SW):   n = S_MEM_ADR;
          (o == OP_R):                    n = S_EXE_R;
          (o == OP_ADDIU) || (o == OP_ORI): n = S_EXE_I;
          (o == OP_BEQ):                  n = S_BRANCH;
          (o == OP_J):                    n = S_JUMP;
          default:                        n = S_FETCH;
        endcase
      end
      S_MEM_ADR: n = (o == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  n = S_MEM_WB;
      S_EXE_R:   n = known_funct(f) ? S_ALU_WB : S_FETCH;
      S_EXE_I:   n = S_ALU_WB;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  // op/funct are held by IR from DECODE on, so decoding them on entry is safe
  function automatic ctl_t decode(
    input state_t     s,
    input logic [5:0] o,
    input logic [5:0] f
  );
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_wr    = 1'b1;
        c.pc_wr    = 1'b1;
        c.pc_src   = PC_SEQ;
        c.alu_srcb = SB_FOUR;
      end
      S_DECODE: begin
        c.alu_srcb = SB_BOFS;
        c.ext_op   = 1'b1;
      end
      S_MEM_ADR: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SB_IMM;
        c.ext_op   = 1'b1;
      end
      S_MEM_WB: begin
        c.rf_wr  = 1'b1;
        c.wd_sel = 1'b1;
      end
      S_MEM_WR: c.dm_wr = 1'b1;
      S_EXE_R: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SB_B;
        c.alu      = r_alu(f);
      end
      S_EXE_I: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SB_IMM;
        c.ext_op   = (o == OP_ADDIU);
        c.alu      = (o == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_ALU_WB: begin
        c.rf_wr   = 1'b1;
        c.reg_dst = (o == OP_R);
      end
      S_BRANCH: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SB_B;
        c.alu      = ALU_SUB;
        c.pc_src   = PC_BR;
      end
      S_JUMP: begin
        c.pc_wr  = 1'b1;
        c.pc_src = PC_JMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt   = next_of(cur, op, funct);
    ctl_d = decode(nxt, op, funct);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= state_t'(RESET_STATE);
      ctl_q <= decode(state_t'(RESET_STATE), op, funct);
    end else begin
      cur   <= nxt;
      ctl_q <= ctl_d;
    end
  end

  // write enables are squashed combinationally for the whole reset window
  assign pc_wr    = ~rst & (ctl_q.pc_wr | ((cur == S_BRANCH) & Zero));
  assign ir_wr    = ~rst & ctl_q.ir_wr;
  assign rf_wr    = ~rst & ctl_q.rf_wr;
  assign dm_wr    = ~rst & ctl_q.dm_wr;
  assign pc_src   = ctl_q.pc_src;
  assign reg_dst  = ctl_q.reg_dst;
  assign wd_sel   = ctl_q.wd_sel;
  assign alu_srca = ctl_q.alu_srca;
  assign alu_srcb = ctl_q.alu_srcb;
  assign ext_op   = ctl_q.ext_op;
  assign ALUop    = ctl_q.alu;
  assign state    = cur;

endmodule
